// File: rtl/cd_efm_frame_sync.sv
// -----------------------------------------------------------------------------
// cd_efm_frame_sync
//
// Frame synchroniser for the audio CD decoder path. Consumes the NRZI-decoded
// EFM channel-bit stream, hunts for the frame sync pattern and qualifies lock
// over consecutive correctly spaced syncs. Once locked, it flywheels through
// isolated missed syncs and slices each frame into 14-bit EFM symbols. Each
// symbol is tagged with its position in the frame.
//
// Frame layout by bit position (pos 0 is the bit after the last sync bit):
//   0..2                 merging bits
//   3+17k .. 16+17k      EFM symbol k
//   17+17k .. 19+17k     merging bits after symbol k
//   last SYNC_BITS bits  sync pattern
//
// Ports:
//   clk          clock
//   rst          synchronous active-high reset
//   bit_in       channel bit
//   bit_valid    bit_in is valid this cycle
//   sym_data     14-bit symbol; first-received bit in bit 13
//   sym_valid    one-cycle pulse, sym_data/sym_index valid
//   sym_index    symbol position in frame, 0..SYMBOLS-1
//   frame_start  one-cycle pulse, frame boundary accepted
//   sync_miss    one-cycle pulse, expected sync absent while locked
//   locked       frame lock achieved
//   err_count    saturating count of sync misses
//
// All outputs are registered. They appear one cycle after the bit_valid cycle
// that causes them. SYNC_BITS must be at least 14, because the symbol is taken
// from the tail of the sync shift register.
// -----------------------------------------------------------------------------
module cd_efm_frame_sync #(
  parameter int                   SYMBOLS      = 33,
  parameter int                   SYNC_BITS    = 24,
  parameter logic [SYNC_BITS-1:0] SYNC_PATTERN = 24'b100000000001000000000010,
  parameter int                   LOCK_COUNT   = 2,
  parameter int                   UNLOCK_COUNT = 3,
  parameter int                   ERR_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic [13:0]      sym_data,
  output logic             sym_valid,
  output logic [5:0]       sym_index,
  output logic             frame_start,
  output logic             sync_miss,
  output logic             locked,
  output logic [ERR_W-1:0] err_count
);

  localparam int FRAME_BITS = SYNC_BITS + 3 + 17 * SYMBOLS;
  localparam int PW         = $clog2(FRAME_BITS);
  localparam int GW         = $clog2(LOCK_COUNT + 1);
  localparam int MW         = $clog2(UNLOCK_COUNT + 1);

  localparam logic [PW-1:0] POS_LAST = PW'(FRAME_BITS - 1);

  localparam logic [1:0] ST_HUNT   = 2'd0;
  localparam logic [1:0] ST_VERIFY = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  // State registers
  logic [1:0]           state_r;
  logic [SYNC_BITS-1:0] shreg_r;
  logic [PW-1:0]        pos_r;
  logic [GW-1:0]        good_r;
  logic [MW-1:0]        miss_r;
  logic [ERR_W-1:0]     err_r;
  logic                 locked_r;
  logic [13:0]          sym_data_r;
  logic [5:0]           sym_index_r;
  logic                 sym_valid_r;
  logic                 frame_start_r;
  logic                 sync_miss_r;

  // Next-state values
  logic [1:0]           state_s;
  logic [SYNC_BITS-1:0] shreg_s;
  logic [PW-1:0]        pos_s;
  logic [GW-1:0]        good_s;
  logic [MW-1:0]        miss_s;
  logic [ERR_W-1:0]     err_s;
  logic                 locked_s;
  logic [13:0]          sym_data_s;
  logic [5:0]           sym_index_s;
  logic                 sym_valid_s;
  logic                 frame_start_s;
  logic                 sync_miss_s;

  // Helpers
  logic [SYNC_BITS-1:0] shift_s;
  logic                 match_s;
  logic                 boundary_s;
  logic [GW-1:0]        good_inc_s;
  logic [MW-1:0]        miss_inc_s;
  logic [ERR_W-1:0]     err_sat_s;
  logic                 sym_hit_s;
  logic [5:0]           sym_k_s;

  // Compare pos against every symbol-end position. Symbol k ends at
  // 16 + 17k, and the matching k becomes the index.
  always_comb begin
    sym_hit_s = 1'b0;
    sym_k_s   = 6'd0;
    for (int k = 0; k < SYMBOLS; k++) begin
      sym_hit_s = sym_hit_s | (pos_r == PW'(16 + 17 * k));
      sym_k_s   = (pos_r == PW'(16 + 17 * k)) ? 6'(k) : sym_k_s;
    end
  end

  // Shift window, sync match and counter increments for the current bit
  always_comb begin
    shift_s    = {shreg_r[SYNC_BITS-2:0], bit_in};
    match_s    = (shift_s == SYNC_PATTERN);
    boundary_s = (pos_r == POS_LAST);
    good_inc_s = good_r + GW'(1);
    miss_inc_s = miss_r + MW'(1);
    err_sat_s  = (err_r == {ERR_W{1'b1}}) ? err_r : err_r + ERR_W'(1);
  end

  // Hunt / verify / locked state machine and output event generation
  always_comb begin
    state_s       = state_r;
    shreg_s       = shreg_r;
    pos_s         = pos_r;
    good_s        = good_r;
    miss_s        = miss_r;
    err_s         = err_r;
    locked_s      = locked_r;
    sym_data_s    = sym_data_r;
    sym_index_s   = sym_index_r;
    sym_valid_s   = 1'b0;
    frame_start_s = 1'b0;
    sync_miss_s   = 1'b0;

    if (bit_valid) begin
      shreg_s = shift_s;
      case (state_r)
        ST_HUNT: begin
          if (match_s) begin
            pos_s  = '0;
            good_s = GW'(1);
            miss_s = '0;
            if (LOCK_COUNT == 1) begin
              state_s       = ST_LOCKED;
              locked_s      = 1'b1;
              frame_start_s = 1'b1;
            end else begin
              state_s = ST_VERIFY;
            end
          end else begin
            pos_s = pos_r;
          end
        end

        ST_VERIFY: begin
          // Only the expected boundary is examined. A pattern elsewhere in the
          // frame is treated as data.
          if (boundary_s) begin
            pos_s = '0;
            if (match_s) begin
              good_s = good_inc_s;
              if (good_inc_s == GW'(LOCK_COUNT)) begin
                state_s       = ST_LOCKED;
                locked_s      = 1'b1;
                frame_start_s = 1'b1;
                miss_s        = '0;
              end else begin
                state_s = ST_VERIFY;
              end
            end else begin
              state_s = ST_HUNT;
              good_s  = '0;
            end
          end else begin
            pos_s = pos_r + PW'(1);
          end
        end

        ST_LOCKED: begin
          if (boundary_s) begin
            pos_s = '0;
            if (match_s) begin
              miss_s        = '0;
              frame_start_s = 1'b1;
            end else begin
              sync_miss_s = 1'b1;
              err_s       = err_sat_s;
              miss_s      = miss_inc_s;
              if (miss_inc_s == MW'(UNLOCK_COUNT)) begin
                // Lock lost. Hunting resumes with the next valid bit.
                state_s  = ST_HUNT;
                locked_s = 1'b0;
                miss_s   = '0;
                good_s   = '0;
              end else begin
                // Flywheel: keep the frame timing as if the sync were present.
                frame_start_s = 1'b1;
              end
            end
          end else begin
            pos_s = pos_r + PW'(1);
            if (sym_hit_s) begin
              sym_valid_s = 1'b1;
              sym_data_s  = shift_s[13:0];
              sym_index_s = sym_k_s;
            end else begin
              sym_valid_s = 1'b0;
            end
          end
        end

        default: begin
          state_s  = ST_HUNT;
          locked_s = 1'b0;
          pos_s    = '0;
          good_s   = '0;
          miss_s   = '0;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // Register state and outputs. Synchronous reset clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_HUNT;
      shreg_r       <= '0;
      pos_r         <= '0;
      good_r        <= '0;
      miss_r        <= '0;
      err_r         <= '0;
      locked_r      <= 1'b0;
      sym_data_r    <= 14'd0;
      sym_index_r   <= 6'd0;
      sym_valid_r   <= 1'b0;
      frame_start_r <= 1'b0;
      sync_miss_r   <= 1'b0;
    end else begin
      state_r       <= state_s;
      shreg_r       <= shreg_s;
      pos_r         <= pos_s;
      good_r        <= good_s;
      miss_r        <= miss_s;
      err_r         <= err_s;
      locked_r      <= locked_s;
      sym_data_r    <= sym_data_s;
      sym_index_r   <= sym_index_s;
      sym_valid_r   <= sym_valid_s;
      frame_start_r <= frame_start_s;
      sync_miss_r   <= sync_miss_s;
    end
  end

  assign sym_data    = sym_data_r;
  assign sym_valid   = sym_valid_r;
  assign sym_index   = sym_index_r;
  assign frame_start = frame_start_r;
  assign sync_miss   = sync_miss_r;
  assign locked      = locked_r;
  assign err_count   = err_r;

endmodule

// File: tb/tb_cd_efm_frame_sync.sv
// -----------------------------------------------------------------------------
// tb_cd_efm_frame_sync
//
// Scoreboard bench for cd_efm_frame_sync. Two instances are used:
//   dut0: default build (33 symbols, 588-bit frames)
//   dut1: SYMBOLS=4 (95-bit frames), ERR_W=2 so saturation is reachable
//
// Stimulus builds each frame bit by bit. At the bit that should cause an
// output event, it pushes the expected event record. Each instance has its own
// monitor, which pops a record on every output pulse and compares it.
// -----------------------------------------------------------------------------
module tb_cd_efm_frame_sync;

  localparam logic [23:0] PAT = 24'b100000000001000000000010;

  typedef struct packed {
    logic        sv;
    logic [5:0]  idx;
    logic [13:0] data;
    logic        fs;
    logic        sm;
    logic        lk;
    logic [7:0]  err;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  bit_in_s;
  logic [1:0]  bit_valid_s;

  logic [13:0] sym_data0_s;
  logic        sym_valid0_s;
  logic [5:0]  sym_index0_s;
  logic        frame_start0_s;
  logic        sync_miss0_s;
  logic        locked0_s;
  logic [7:0]  err_count0_s;

  logic [13:0] sym_data1_s;
  logic        sym_valid1_s;
  logic [5:0]  sym_index1_s;
  logic        frame_start1_s;
  logic        sync_miss1_s;
  logic        locked1_s;
  logic [1:0]  err_count1_s;

  ev_t q0[$];
  ev_t q1[$];
  ev_t act0_r;
  ev_t exp0_r;
  ev_t act1_r;
  ev_t exp1_r;

  int  checks = 0;
  int  errors = 0;
  int  exp_err[2];
  bit  gap_mode;

  always #5 clk = ~clk;

  cd_efm_frame_sync dut0 (
    .clk         (clk),
    .rst         (rst),
    .bit_in      (bit_in_s[0]),
    .bit_valid   (bit_valid_s[0]),
    .sym_data    (sym_data0_s),
    .sym_valid   (sym_valid0_s),
    .sym_index   (sym_index0_s),
    .frame_start (frame_start0_s),
    .sync_miss   (sync_miss0_s),
    .locked      (locked0_s),
    .err_count   (err_count0_s)
  );

  cd_efm_frame_sync #(.SYMBOLS(4), .ERR_W(2)) dut1 (
    .clk         (clk),
    .rst         (rst),
    .bit_in      (bit_in_s[1]),
    .bit_valid   (bit_valid_s[1]),
    .sym_data    (sym_data1_s),
    .sym_valid   (sym_valid1_s),
    .sym_index   (sym_index1_s),
    .frame_start (frame_start1_s),
    .sync_miss   (sync_miss1_s),
    .locked      (locked1_s),
    .err_count   (err_count1_s)
  );

  // Monitor for dut0: every output pulse must match the next expected record
  always @(negedge clk) begin
    if (!rst && (sym_valid0_s || frame_start0_s || sync_miss0_s)) begin
      act0_r      = '0;
      act0_r.sv   = sym_valid0_s;
      act0_r.idx  = sym_valid0_s ? sym_index0_s : 6'd0;
      act0_r.data = sym_valid0_s ? sym_data0_s : 14'd0;
      act0_r.fs   = frame_start0_s;
      act0_r.sm   = sync_miss0_s;
      act0_r.lk   = locked0_s;
      act0_r.err  = err_count0_s;
      checks++;
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL dut0_unexpected_event actual=%h required=none", act0_r);
      end else begin
        exp0_r = q0.pop_front();
        if (act0_r !== exp0_r) begin
          errors++;
          $display("FAIL dut0_event actual sv=%0d idx=%0d data=%h fs=%0d sm=%0d lk=%0d err=%0d required sv=%0d idx=%0d data=%h fs=%0d sm=%0d lk=%0d err=%0d",
                   act0_r.sv, act0_r.idx, act0_r.data, act0_r.fs, act0_r.sm, act0_r.lk, act0_r.err,
                   exp0_r.sv, exp0_r.idx, exp0_r.data, exp0_r.fs, exp0_r.sm, exp0_r.lk, exp0_r.err);
        end
      end
    end
  end

  // Monitor for dut1 (SYMBOLS=4, ERR_W=2)
  always @(negedge clk) begin
    if (!rst && (sym_valid1_s || frame_start1_s || sync_miss1_s)) begin
      act1_r      = '0;
      act1_r.sv   = sym_valid1_s;
      act1_r.idx  = sym_valid1_s ? sym_index1_s : 6'd0;
      act1_r.data = sym_valid1_s ? sym_data1_s : 14'd0;
      act1_r.fs   = frame_start1_s;
      act1_r.sm   = sync_miss1_s;
      act1_r.lk   = locked1_s;
      act1_r.err  = {6'd0, err_count1_s};
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL dut1_unexpected_event actual=%h required=none", act1_r);
      end else begin
        exp1_r = q1.pop_front();
        if (act1_r !== exp1_r) begin
          errors++;
          $display("FAIL dut1_event actual sv=%0d idx=%0d data=%h fs=%0d sm=%0d lk=%0d err=%0d required sv=%0d idx=%0d data=%h fs=%0d sm=%0d lk=%0d err=%0d",
                   act1_r.sv, act1_r.idx, act1_r.data, act1_r.fs, act1_r.sm, act1_r.lk, act1_r.err,
                   exp1_r.sv, exp1_r.idx, exp1_r.data, exp1_r.fs, exp1_r.sm, exp1_r.lk, exp1_r.err);
        end
      end
    end
  end

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Drive one valid bit, with optional random idle gaps first. When requested,
  // push the expected record before the clock edge that consumes the bit.
  task automatic send_bit(input int inst, input logic b, input bit do_push, input ev_t ev);
    int n;
    n = 0;
    if (gap_mode) begin
      while (n < 4 && $urandom_range(0, 1) == 1) begin
        @(posedge clk);
        #1;
        n++;
      end
    end
    bit_in_s[inst]    = b;
    bit_valid_s[inst] = 1'b1;
    if (do_push) begin
      if (inst == 0) q0.push_back(ev);
      else           q1.push_back(ev);
    end
    @(posedge clk);
    #1;
    bit_valid_s[inst] = 1'b0;
  endtask

  task automatic send_sync(input int inst);
    logic [23:0] pat_v;
    pat_v = PAT;
    for (int j = 0; j < 24; j++) send_bit(inst, pat_v[23-j], 1'b0, '0);
  endtask

  // Send one full frame: merging bits, symbols 14'h0480+k and a sync at the end.
  //   syms    : symbol events expected (locked during this frame)
  //   corrupt : clear the middle 1 of the sync
  //   embed   : put the sync pattern inside the data region at pos 40..63
  //   ev_code : sync event at last bit: 0 none, 1 frame_start, 2 miss+flywheel, 3 miss+drop
  task automatic send_frame(input int inst, input bit syms, input bit corrupt,
                            input bit embed, input int ev_code);
    logic        fbuf [0:587];
    logic [23:0] pat_v;
    logic [13:0] sym;
    ev_t         e;
    bit          push;
    int          nsym;
    int          fbits;
    int          maxerr;
    pat_v  = PAT;
    nsym   = (inst == 0) ? 33 : 4;
    maxerr = (inst == 0) ? 255 : 3;
    fbits  = 27 + 17 * nsym;
    for (int p = 0; p < 588; p++) fbuf[p] = 1'b0;
    for (int k = 0; k < nsym; k++) begin
      sym = 14'h0480 + 14'(k);
      for (int j = 0; j < 14; j++) fbuf[3 + 17*k + j] = sym[13-j];
    end
    for (int j = 0; j < 24; j++) fbuf[fbits - 24 + j] = pat_v[23-j];
    if (corrupt) fbuf[fbits - 24 + 11] = 1'b0;
    if (embed) begin
      for (int j = 0; j < 24; j++) fbuf[40 + j] = pat_v[23-j];
    end
    for (int p = 0; p < fbits; p++) begin
      e    = '0;
      push = 1'b0;
      if (syms && p >= 16 && ((p - 16) % 17) == 0 && ((p - 16) / 17) < nsym) begin
        e.sv  = 1'b1;
        e.idx = 6'((p - 16) / 17);
        for (int j = 0; j < 14; j++) e.data[13-j] = fbuf[p - 13 + j];
        e.lk  = 1'b1;
        e.err = 8'(exp_err[inst]);
        push  = 1'b1;
      end
      if (p == fbits - 1 && ev_code != 0) begin
        if (ev_code >= 2 && exp_err[inst] < maxerr) exp_err[inst]++;
        e.fs  = (ev_code == 1 || ev_code == 2);
        e.sm  = (ev_code >= 2);
        e.lk  = (ev_code != 3);
        e.err = 8'(exp_err[inst]);
        push  = 1'b1;
      end
      send_bit(inst, fbuf[p], push, e);
    end
  endtask

  task automatic check_dut0_zero(input string tag);
    check_val({tag, "_sym_valid"},   {31'd0, sym_valid0_s},   32'd0);
    check_val({tag, "_frame_start"}, {31'd0, frame_start0_s}, 32'd0);
    check_val({tag, "_sync_miss"},   {31'd0, sync_miss0_s},   32'd0);
    check_val({tag, "_locked"},      {31'd0, locked0_s},      32'd0);
    check_val({tag, "_err_count"},   {24'd0, err_count0_s},   32'd0);
    check_val({tag, "_sym_data"},    {18'd0, sym_data0_s},    32'd0);
    check_val({tag, "_sym_index"},   {26'd0, sym_index0_s},   32'd0);
  endtask

  initial begin
    rst         = 1'b1;
    bit_in_s    = 2'b00;
    bit_valid_s = 2'b00;
    gap_mode    = 1'b0;
    exp_err[0]  = 0;
    exp_err[1]  = 0;
    repeat (3) @(posedge clk);
    #1;
    check_dut0_zero("reset");
    check_val("reset_dut1_locked", {31'd0, locked1_s},    32'd0);
    check_val("reset_dut1_err",    {30'd0, err_count1_s}, 32'd0);
    rst = 1'b0;

    // Clean lock: sync #1 enters verify, sync #2 locks, then symbols flow
    send_sync(0);
    send_frame(0, 1'b0, 1'b0, 1'b0, 1);
    send_frame(0, 1'b1, 1'b0, 1'b0, 1);
    send_frame(0, 1'b1, 1'b0, 1'b0, 1);

    // Isolated misses flywheel and never drop lock
    send_frame(0, 1'b1, 1'b1, 1'b0, 2);
    send_frame(0, 1'b1, 1'b0, 1'b0, 1);
    send_frame(0, 1'b1, 1'b1, 1'b0, 2);
    send_frame(0, 1'b1, 1'b0, 1'b0, 1);

    // Sync pattern inside the data while locked is ignored
    send_frame(0, 1'b1, 1'b0, 1'b1, 1);

    // Three consecutive misses drop lock at the third
    send_frame(0, 1'b1, 1'b1, 1'b0, 2);
    send_frame(0, 1'b1, 1'b1, 1'b0, 2);
    send_frame(0, 1'b1, 1'b1, 1'b0, 3);
    check_val("drop_locked", {31'd0, locked0_s}, 32'd0);
    check_val("drop_err",    {24'd0, err_count0_s}, 32'd5);

    // Relock: the next sync enters verify, and the pattern inside the data is ignored in verify
    send_frame(0, 1'b0, 1'b0, 1'b0, 0);
    send_frame(0, 1'b0, 1'b0, 1'b1, 1);
    send_frame(0, 1'b1, 1'b0, 1'b0, 1);

    // Reset mid-stream while locked. pos stays below 16, so no symbol is due.
    for (int i = 0; i < 10; i++) send_bit(0, 1'(i % 2), 1'b0, '0);
    rst            = 1'b1;
    bit_in_s[0]    = 1'b1;
    bit_valid_s[0] = 1'b1;
    @(posedge clk);
    #1;
    check_dut0_zero("midrst");
    rst            = 1'b0;
    bit_valid_s[0] = 1'b0;
    exp_err[0]     = 0;

    // Lock again after reset, as from power-up
    send_sync(0);
    send_frame(0, 1'b0, 1'b0, 1'b0, 1);
    send_frame(0, 1'b1, 1'b0, 1'b0, 1);

    // Same kind of stream with random bit_valid gaps
    gap_mode = 1'b1;
    send_frame(0, 1'b1, 1'b0, 1'b0, 1);
    send_frame(0, 1'b1, 1'b1, 1'b0, 2);
    send_frame(0, 1'b1, 1'b0, 1'b0, 1);
    send_frame(0, 1'b1, 1'b1, 1'b0, 2);
    send_frame(0, 1'b1, 1'b1, 1'b0, 2);
    send_frame(0, 1'b1, 1'b1, 1'b0, 3);
    send_frame(0, 1'b0, 1'b0, 1'b0, 0);
    send_frame(0, 1'b0, 1'b0, 1'b0, 1);
    send_frame(0, 1'b1, 1'b0, 1'b0, 1);
    gap_mode = 1'b0;

    // SYMBOLS=4 build: lock, indices 0..3, error counter saturates at 3
    send_sync(1);
    send_frame(1, 1'b0, 1'b0, 1'b0, 1);
    send_frame(1, 1'b1, 1'b0, 1'b0, 1);
    for (int r = 0; r < 4; r++) begin
      send_frame(1, 1'b1, 1'b1, 1'b0, 2);
      send_frame(1, 1'b1, 1'b0, 1'b0, 1);
    end
    check_val("dut1_err_saturated", {30'd0, err_count1_s}, 32'd3);
    check_val("dut1_locked",        {31'd0, locked1_s},    32'd1);

    repeat (5) @(posedge clk);
    #1;
    check_val("dut0_pending_events", 32'(q0.size()), 32'd0);
    check_val("dut1_pending_events", 32'(q1.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
